pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- Program-counter register and instruction-fetch stage. It sits directly downstream of the branch/jump decision logic and consumes its 1-bit PC-select output.
- Holds the PC, drives the instruction-memory address, and tolerates memory wait states.
- Captures fetched instructions into the IF/ID pipeline register.
- On a taken branch or jump it loads the target PC and squashes the in-flight fetch.

Parameters:
- ADDR_W, 32, PC and target width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 1, sequential increment (word-addressed memory)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_pc_sel  input  1  1 = redirect PC to in_target (taken branch or jump)
- in_target  input  ADDR_W  redirect target address
- in_stall  input  1  downstream hazard stall; hold PC and IF/ID
- in_halt  input  1  halt decoded in ID; stop fetching
- in_imem_rdata  input  INSTR_W  instruction read data
- in_imem_ready  input  1  in_imem_rdata valid this cycle for out_imem_addr
- out_imem_addr  output  ADDR_W  fetch address = PC register
- out_imem_req  output  1  fetch request
- out_if_pc  output  ADDR_W  IF/ID: PC of the held instruction
- out_if_instr  output  INSTR_W  IF/ID: instruction
- out_if_valid  output  1  IF/ID holds a real instruction
- out_halted  output  1  stage is in HALTED

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All state is cleared immediately on reset assertion, independent of clk.
- Reset values: PC=RESET_PC, out_if_pc=0, out_if_instr=0, out_if_valid=0, out_halted=0, FSM=BOOT. Therefore out_imem_addr=RESET_PC and out_imem_req=0.
- FSM states:
  - BOOT: lasts one cycle after reset deasserts; req=0; then goes to RUN unconditionally.
  - RUN: normal fetching.
  - HALTED: sticky; only reset exits it.
- out_imem_req = 1 only in RUN. It is combinational from the state.
- RUN priority per rising edge, highest first:
  1. in_pc_sel=1: PC <= in_target; out_if_valid <= 0 (squash); stay RUN. Applies regardless of in_stall, in_halt and in_imem_ready.
  2. in_halt=1: go to HALTED; PC holds; out_if_valid <= 0.
  3. in_stall=1: PC, out_if_pc, out_if_instr and out_if_valid all hold.
  4. in_imem_ready=1: out_if_pc <= PC; out_if_instr <= in_imem_rdata; out_if_valid <= 1; PC <= PC+PC_STEP.
  5. Otherwise (memory wait): PC holds; out_if_valid <= 0 (bubble); instruction fields hold.
- Redirect vs halt in the same cycle: redirect wins. The halting instruction is younger and gets squashed.
- Redirect during a memory wait: the outstanding fetch is abandoned. The next cycle presents in_target on out_imem_addr. The memory must accept an address change while ready=0.
- HALTED: req=0; PC, out_if_pc and out_if_instr hold; out_if_valid=0; out_halted=1. in_pc_sel and in_stall are ignored.
- BOOT: in_pc_sel, in_stall and in_halt are ignored.
- Arithmetic: PC+PC_STEP is modulo 2^ADDR_W, so it wraps to 0 with no flag. in_target is used unmodified (no alignment masking).
- Latency: an instruction accepted at edge N is visible on the out_if_* outputs after edge N. Redirect-to-first-valid takes 2 edges with a zero-wait memory: the redirect edge, then the fetch of the target.
- Reset mid-operation (wait state, stall or HALTED): immediate return to reset values; any pending fetch is discarded.

Decomposition:
- Shared package:
  - FSM state encoding: BOOT=2'd0, RUN=2'd1, HALTED=2'd2.
  - RESET_PC and PC_STEP defaults, for reuse by decode and branch logic.
- One natural sub-module: if_id_reg. It holds pc/instr/valid and takes load, hold and squash controls. The FSM and PC datapath stay in the top module.

Test Plan:
- Reset and boot: assert reset mid-cycle -> outputs take reset values with no clock edge. Release -> req=0 for one cycle, then req=1 with addr=0.
- Sequential fetch, zero-wait memory (ready=1, rdata=mem[addr]) -> IF/ID sequence (0,mem[0]), (1,mem[1]), (2,mem[2]) on consecutive cycles with valid=1.
- Wait states: ready low 2 cycles at addr 3 -> addr holds at 3 and valid=0 for 2 cycles, then (3,mem[3]) valid.
- Redirect: at PC=5, pulse pc_sel with target 0x40, ready=1 and stall=1 in the same cycle -> valid=0 next cycle, addr=0x40, then (0x40,mem[0x40]) valid.
- Stall: stall held 3 cycles with IF/ID=(7,X) -> IF/ID and PC unchanged throughout. After release, the fetch of PC 8 completes.
- Halt and conflicts:
  - halt with pc_sel=0 -> HALTED, req=0, out_halted=1; later pc_sel pulses are ignored.
  - halt with pc_sel=1 in the same cycle -> stays RUN at the target.
  - PC=0xFFFFFFFF with ready=1 -> next PC=0.

Source files
------------

// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encoding and PC defaults
// that decode and branch logic reuse to agree on reset vector and stride.
package pc_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_PC_STEP  = 1;

endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Control priority: hold, then squash, then load.
// With no control asserted all fields keep their value.
module pc_fetch_stage_if_id_reg #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_hold,
  input  logic               i_squash,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
);

  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;

  // A squash only kills valid; pc/instr keep the last fetched values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_pc    <= r_pc;
      r_instr <= r_instr;
      r_valid <= r_valid;
    end else if (i_squash) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter and instruction fetch: BOOT/RUN/HALTED sequencing,
// redirect on taken branch/jump, memory wait-state tolerance, IF/ID capture.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEF_PC_STEP)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_pc_sel,
  input  logic [ADDR_W-1:0]  in_target,
  input  logic               in_stall,
  input  logic               in_halt,
  input  logic [INSTR_W-1:0] in_imem_rdata,
  input  logic               in_imem_ready,
  output logic [ADDR_W-1:0]  out_imem_addr,
  output logic               out_imem_req,
  output logic [ADDR_W-1:0]  out_if_pc,
  output logic [INSTR_W-1:0] out_if_instr,
  output logic               out_if_valid,
  output logic               out_halted
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_load;
  logic              w_hold;
  logic              w_squash;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Redirect outranks halt: the halting instruction is younger than the
  // branch and is squashed with the rest of the wrong path.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_hold      = 1'b0;
    w_squash    = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
        w_hold      = 1'b1;
      end
      ST_RUN: begin
        if (in_pc_sel) begin
          w_pc_nxt = in_target;
          w_squash = 1'b1;
        end else if (in_halt) begin
          w_state_nxt = ST_HALTED;
          w_squash    = 1'b1;
        end else if (in_stall) begin
          w_hold = 1'b1;
        end else if (in_imem_ready) begin
          w_pc_nxt = r_pc + PC_STEP;
          w_load   = 1'b1;
        end else begin
          w_squash = 1'b1;
        end
      end
      ST_HALTED: begin
        w_squash = 1'b1;
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_squash    = 1'b1;
      end
    endcase
  end

  pc_fetch_stage_if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_load),
    .i_hold  (w_hold),
    .i_squash(w_squash),
    .i_pc    (r_pc),
    .i_instr (in_imem_rdata),
    .o_pc    (out_if_pc),
    .o_instr (out_if_instr),
    .o_valid (out_if_valid)
  );

  assign out_imem_addr = r_pc;
  assign out_imem_req  = (r_state == ST_RUN);
  assign out_halted    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: a rule-level model checked every
// negedge, plus literal expectations at key points of the sequence.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] target = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] rdata;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;

  int n_total = 0;
  int n_pass  = 0;

  pc_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_pc_sel    (pc_sel),
    .in_target    (target),
    .in_stall     (stall),
    .in_halt      (halt),
    .in_imem_rdata(rdata),
    .in_imem_ready(ready),
    .out_imem_addr(imem_addr),
    .out_imem_req (imem_req),
    .out_if_pc    (if_pc),
    .out_if_instr (if_instr),
    .out_if_valid (if_valid),
    .out_halted   (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // Model: stage-level rules with booting/halted flags.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_if_pc = 32'h0;
  logic [31:0] m_if_instr = 32'h0;
  logic        m_if_valid = 1'b0;
  logic        m_booting = 1'b1;
  logic        m_halted = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_if_pc = 32'h0; m_if_instr = 32'h0;
      m_if_valid = 1'b0; m_booting = 1'b1; m_halted = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (!m_halted) begin
      if (pc_sel) begin
        m_pc = target; m_if_valid = 1'b0;
      end else if (halt) begin
        m_halted = 1'b1; m_if_valid = 1'b0;
      end else if (stall) begin
        // everything holds
      end else if (ready) begin
        m_if_pc = m_pc; m_if_instr = mem_word(m_pc); m_if_valid = 1'b1;
        m_pc = m_pc + 32'd1;
      end else begin
        m_if_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_addr",   imem_addr,       m_pc);
    chk("m_req",    32'(imem_req),   32'(!m_booting && !m_halted));
    chk("m_halted", 32'(halted),     32'(m_halted));
    chk("m_valid",  32'(if_valid),   32'(m_if_valid));
    chk("m_if_pc",  if_pc,           m_if_pc);
    chk("m_instr",  if_instr,        m_if_instr);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_if(input string name, input logic [31:0] pc, input logic v);
    chk({name, "_valid"}, 32'(if_valid), 32'(v));
    chk({name, "_pc"}, if_pc, pc);
    if (v) chk({name, "_instr"}, if_instr, mem_word(pc));
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_addr",   imem_addr,       32'h0);
    chk("rst_req",    32'(imem_req),   32'h0);
    chk("rst_valid",  32'(if_valid),   32'h0);
    chk("rst_halted", 32'(halted),     32'h0);
    #10 reset = 1'b0;
    ready = 1'b1;
    #1 chk("boot_req", 32'(imem_req), 32'h0);
    tick();
    chk("run_req",  32'(imem_req), 32'h1);
    chk("run_addr", imem_addr,     32'h0);

    tick(); chk_if("seq0", 32'h0, 1'b1);
    tick(); chk_if("seq1", 32'h1, 1'b1);
    tick(); chk_if("seq2", 32'h2, 1'b1);
    chk("seq_addr", imem_addr, 32'h3);

    ready = 1'b0;
    tick(); chk("wait1_addr", imem_addr, 32'h3); chk("wait1_valid", 32'(if_valid), 32'h0);
    tick(); chk("wait2_addr", imem_addr, 32'h3); chk("wait2_valid", 32'(if_valid), 32'h0);
    ready = 1'b1;
    tick(); chk_if("wait_done", 32'h3, 1'b1);
    tick(); chk("pre_redir_addr", imem_addr, 32'h5);

    pc_sel = 1'b1; target = 32'h40; stall = 1'b1;
    tick();
    chk("redir_valid", 32'(if_valid), 32'h0);
    chk("redir_addr",  imem_addr,     32'h40);
    pc_sel = 1'b0; stall = 1'b0;
    tick(); chk_if("redir_fetch", 32'h40, 1'b1);

    pc_sel = 1'b1; target = 32'h6;
    tick(); pc_sel = 1'b0;
    tick(); tick(); chk_if("pre_stall", 32'h7, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_if("stall", 32'h7, 1'b1);
      chk("stall_addr", imem_addr, 32'h8);
    end
    stall = 1'b0;
    tick(); chk_if("post_stall", 32'h8, 1'b1);

    halt = 1'b1; pc_sel = 1'b1; target = 32'h100;
    tick();
    chk("hr_halted", 32'(halted),   32'h0);
    chk("hr_req",    32'(imem_req), 32'h1);
    chk("hr_addr",   imem_addr,     32'h100);
    halt = 1'b0; pc_sel = 1'b0;

    pc_sel = 1'b1; target = 32'hFFFF_FFFF;
    tick(); pc_sel = 1'b0;
    tick();
    chk_if("wrap", 32'hFFFF_FFFF, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);

    ready = 1'b0; pc_sel = 1'b1; target = 32'h20;
    tick(); pc_sel = 1'b0;
    chk("wredir_addr", imem_addr, 32'h20);
    chk("wredir_valid", 32'(if_valid), 32'h0);
    ready = 1'b1;
    tick(); chk_if("wredir_fetch", 32'h20, 1'b1);

    halt = 1'b1;
    tick(); halt = 1'b0;
    chk("halt_halted", 32'(halted),   32'h1);
    chk("halt_req",    32'(imem_req), 32'h0);
    chk("halt_valid",  32'(if_valid), 32'h0);
    pc_sel = 1'b1; target = 32'h55;
    tick(); tick();
    chk("halt_sticky", 32'(halted), 32'h1);
    chk("halt_addr",   imem_addr,   32'h21);
    chk("halt_if_pc",  if_pc,       32'h20);
    pc_sel = 1'b0;

    #1 reset = 1'b1;
    #1;
    chk("rst2_addr",   imem_addr,     32'h0);
    chk("rst2_halted", 32'(halted),   32'h0);
    chk("rst2_valid",  32'(if_valid), 32'h0);
    chk("rst2_if_pc",  if_pc,         32'h0);
    #4 reset = 1'b0;
    tick();
    chk("reboot_req", 32'(imem_req), 32'h1);
    tick(); chk_if("reboot0", 32'h0, 1'b1);
    tick(); chk_if("reboot1", 32'h1, 1'b1);

    #5;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
